keypad_scanner: RTL and testbench

//  Parametrised matrix-keypad scanner: drives one-hot column strobes and samples row inputs.

---
 rtl/keypad_pkg.sv | 23 ++
 rtl/keypad_scanner_tick_gen.sv | 25 ++
 rtl/keypad_scanner.sv | 187 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared state type and index helpers for the matrix-keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        PRESS   = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } scan_state_t;

    function automatic int unsigned key_code_of(input int unsigned row,
                                                input int unsigned col,
                                                input int unsigned ncols);
        return row * ncols + col;
    endfunction

    // Advances the strobed column one place, wrapping the last column back to 0.
    function automatic int unsigned rotate_col(input int unsigned col,
                                               input int unsigned ncols);
        return (col + 32'd1 >= ncols) ? 32'd0 : col + 32'd1;
    endfunction

endpackage

// File: rtl/keypad_scanner_tick_gen.sv
// Scan-tick generator: one-clk pulse every TICK_DIV cycles, first one TICK_DIV cycles after reset.
module scan_tick_gen #(
    parameter int TICK_DIV = 5
) (
    input  logic clk,
    input  logic reset,
    output logic o_tick
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

    assign o_tick = (r_cnt == TW'(TICK_DIV - 1));

endmodule

// File: rtl/keypad_scanner.sv
// Matrix-keypad scanner: strobes columns, locks on and debounces one key, reports it once.
// Build option KEYSCAN_DEBOUNCE_EN enables multi-tick debounce; otherwise presses commit in one tick.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter  int NCOLS          = 4,
    parameter  int NROWS          = 4,
    parameter  int TICK_DIV       = 5,
    parameter  int DEBOUNCE_TICKS = 4,
    parameter  int SYNC_STAGES    = 2,
    localparam int RW  = (NROWS > 1) ? $clog2(NROWS) : 1,
    localparam int CIW = $clog2(NCOLS),
    localparam int CW  = $clog2(NROWS * NCOLS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NROWS-1:0] row_in,
    output logic [NCOLS-1:0] col_out,
    output logic             key_valid,
    output logic [RW-1:0]    key_row,
    output logic [CIW-1:0]   key_col,
    output logic [CW-1:0]    key_code,
    output logic             key_held
);
    scan_state_t                       r_state;
    logic [SYNC_STAGES-1:0][NROWS-1:0] r_sync;
    logic [NROWS-1:0]                  w_rows_s;
    logic                              w_tick;
    logic [NCOLS-1:0]                  r_col_out;
    logic [CIW-1:0]                    r_col_idx;
    logic [CIW-1:0]                    w_next_idx;
    logic [RW-1:0]                     r_cand_row;
    logic [RW-1:0]                     w_low_row;
    logic [RW-1:0]                     r_key_row;
    logic [CIW-1:0]                    r_key_col;
    logic [CW-1:0]                     r_key_code;
    logic [CW-1:0]                     w_code_low;
    logic [CW-1:0]                     w_code_cand;
    logic                              r_key_valid;
    logic                              r_key_held;
    logic                              w_enter_done;
    logic                              w_step_done;

    scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], row_in};
        end
    end

    assign w_rows_s = r_sync[SYNC_STAGES-1];

    // Lowest asserted row wins when several keys share the strobed column.
    always_comb begin
        w_low_row = '0;
        for (int i = NROWS - 1; i >= 0; i--) begin
            if (w_rows_s[i]) begin
                w_low_row = RW'(i);
            end
        end
    end

    assign w_next_idx  = CIW'(rotate_col(32'(r_col_idx), NCOLS));
    assign w_code_low  = CW'(key_code_of(32'(w_low_row), 32'(r_col_idx), NCOLS));
    assign w_code_cand = CW'(key_code_of(32'(r_cand_row), 32'(r_col_idx), NCOLS));

`ifdef KEYSCAN_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_TICKS + 1);

    logic [DBW-1:0] r_dbc;
    logic           w_dbc_load;
    logic           w_dbc_inc;

    assign w_dbc_load = w_tick && (((r_state == SCAN) && (w_rows_s != '0)) ||
                                   ((r_state == HELD) && !w_rows_s[r_key_row]));
    assign w_dbc_inc  = w_tick && (((r_state == PRESS) && w_rows_s[r_cand_row]) ||
                                   ((r_state == RELEASE) && !w_rows_s[r_key_row]));
    assign w_enter_done = (DEBOUNCE_TICKS == 1);
    assign w_step_done  = (int'(r_dbc) + 1 >= DEBOUNCE_TICKS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dbc <= '0;
        end else if (w_dbc_load) begin
            r_dbc <= DBW'(1);
        end else if (w_dbc_inc) begin
            r_dbc <= r_dbc + DBW'(1);
        end
    end
`else
    // Every legal DEBOUNCE_TICKS collapses to a single-tick commit in this build.
    assign w_enter_done = (DEBOUNCE_TICKS >= 1);
    assign w_step_done  = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= SCAN;
            r_col_out   <= NCOLS'(1);
            r_col_idx   <= '0;
            r_cand_row  <= '0;
            r_key_valid <= 1'b0;
            r_key_row   <= '0;
            r_key_col   <= '0;
            r_key_code  <= '0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    SCAN: begin
                        if (w_rows_s == '0) begin
                            r_col_idx <= w_next_idx;
                            r_col_out <= NCOLS'(1) << w_next_idx;
                        end else if (w_enter_done) begin
                            r_key_row   <= w_low_row;
                            r_key_col   <= r_col_idx;
                            r_key_code  <= w_code_low;
                            r_key_valid <= 1'b1;
                            r_key_held  <= 1'b1;
                            r_state     <= HELD;
                        end else begin
                            r_cand_row <= w_low_row;
                            r_state    <= PRESS;
                        end
                    end
                    PRESS: begin
                        if (!w_rows_s[r_cand_row]) begin
                            r_col_idx <= w_next_idx;
                            r_col_out <= NCOLS'(1) << w_next_idx;
                            r_state   <= SCAN;
                        end else if (w_step_done) begin
                            r_key_row   <= r_cand_row;
                            r_key_col   <= r_col_idx;
                            r_key_code  <= w_code_cand;
                            r_key_valid <= 1'b1;
                            r_key_held  <= 1'b1;
                            r_state     <= HELD;
                        end
                    end
                    HELD: begin
                        if (!w_rows_s[r_key_row]) begin
                            if (w_enter_done) begin
                                r_key_held <= 1'b0;
                                r_col_idx  <= w_next_idx;
                                r_col_out  <= NCOLS'(1) << w_next_idx;
                                r_state    <= SCAN;
                            end else begin
                                r_state <= RELEASE;
                            end
                        end
                    end
                    RELEASE: begin
                        if (w_rows_s[r_key_row]) begin
                            r_state <= HELD;
                        end else if (w_step_done) begin
                            r_key_held <= 1'b0;
                            r_col_idx  <= w_next_idx;
                            r_col_out  <= NCOLS'(1) << w_next_idx;
                            r_state    <= SCAN;
                        end
                    end
                    default: begin
                        r_state   <= SCAN;
                        r_col_idx <= '0;
                        r_col_out <= NCOLS'(1);
                    end
                endcase
            end
        end
    end

    assign col_out   = r_col_out;
    assign key_valid = r_key_valid;
    assign key_row   = r_key_row;
    assign key_col   = r_key_col;
    assign key_code  = r_key_code;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural key matrix and an event scoreboard.
module tb_keypad_scanner;
    localparam int NCOLS          = 4;
    localparam int NROWS          = 4;
    localparam int TICK_DIV       = 5;
    localparam int DEBOUNCE_TICKS = 4;
    localparam int SYNC_STAGES    = 2;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] c;
        logic [3:0] code;
    } exp_t;

    logic                         clk = 1'b0;
    logic                         reset;
    logic [NROWS-1:0]             row_in;
    logic [NCOLS-1:0]             col_out;
    logic                         key_valid;
    logic [1:0]                   key_row;
    logic [1:0]                   key_col;
    logic [3:0]                   key_code;
    logic                         key_held;
    logic [NROWS-1:0][NCOLS-1:0]  keys;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests    = 0;
    int   n_fail     = 0;
    int   n_pulses   = 0;
    int   n_expected = 0;
    int   drops;

    keypad_scanner #(
        .NCOLS          (NCOLS),
        .NROWS          (NROWS),
        .TICK_DIV       (TICK_DIV),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
        .SYNC_STAGES    (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_valid (key_valid),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_code  (key_code),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Key matrix: a closed key connects its column strobe to its row line.
    always_comb begin
        row_in = '0;
        for (int r = 0; r < NROWS; r++)
            for (int c = 0; c < NCOLS; c++)
                if (keys[r][c] && col_out[c]) row_in[r] = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int r, input int c);
        exp_q.push_back('{r: 2'(r), c: 2'(c), code: 4'(r * NCOLS + c)});
        n_expected++;
    endtask

    task automatic wait_held(input logic val, input int max, input string tag);
        int n = 0;
        while (key_held !== val && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 32'(key_held), 32'(val));
    endtask

    task automatic wait_col(input logic [NCOLS-1:0] target, input int max, input string tag);
        int n = 0;
        while (col_out !== target && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 32'(col_out), 32'(target));
    endtask

    always @(negedge clk) begin
        if (!reset && key_valid === 1'b1) begin
            n_pulses++;
            check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("pulse_row", 32'(key_row), 32'(mon_e.r));
                check("pulse_col", 32'(key_col), 32'(mon_e.c));
                check("pulse_code", 32'(key_code), 32'(mon_e.code));
            end
        end
    end

    initial begin
        keys  = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_col", 32'(col_out), 32'd1);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_code", 32'(key_code), 32'd0);
        check("rst_held", 32'(key_held), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Idle scan: one column step every TICK_DIV clocks
        for (int k = 1; k <= 4; k++) begin
            repeat (TICK_DIV) @(posedge clk);
            #1;
            check("idle_col", 32'(col_out), 32'd1 << (k % 4));
        end

        // Press row2/col2 and hold it
        keys[2][2] = 1'b1;
        push(2, 2);
        wait_held(1'b1, 200, "press_held");
        check("press_valid", 32'(key_valid), 32'd1);
        check("press_row", 32'(key_row), 32'd2);
        check("press_col", 32'(key_col), 32'd2);
        check("press_code", 32'(key_code), 32'd10);
        check("press_colout", 32'(col_out), 32'h4);
        repeat (40) @(posedge clk);
        #1;
        check("hold_colout", 32'(col_out), 32'h4);
        check("hold_held", 32'(key_held), 32'd1);
        check("hold_pulses", 32'(n_pulses), 32'd1);

`ifdef KEYSCAN_DEBOUNCE_EN
        // Release glitch of two ticks must not drop key_held or re-fire
        drops = 0;
        keys[2][2] = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (key_held !== 1'b1) drops++;
        end
        keys[2][2] = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (key_held !== 1'b1) drops++;
        end
        check("glitch_drops", 32'(drops), 32'd0);
        check("glitch_pulses", 32'(n_pulses), 32'd1);
`endif

        // Debounced release resumes scanning at the next column
        keys[2][2] = 1'b0;
        wait_held(1'b0, 60, "rel_held");
        check("rel_colout", 32'(col_out), 32'h8);
        check("rel_code_kept", 32'(key_code), 32'd10);
        check("rel_row_kept", 32'(key_row), 32'd2);

`ifdef KEYSCAN_DEBOUNCE_EN
        // Bounce: two high ticks on row1/col0, then gone
        wait_col(4'b0001, 20, "bnc_align");
        keys[1][0] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        keys[1][0] = 1'b0;
        wait_col(4'b0010, 20, "bnc_resume");
        check("bnc_pulses", 32'(n_pulses), 32'd1);
`else
        // Single-tick commit: row0/col3 for exactly one tick
        wait_col(4'b0001, 20, "t6_align0");
        wait_col(4'b1000, 40, "t6_align3");
        keys[0][3] = 1'b1;
        push(0, 3);
        repeat (TICK_DIV) @(posedge clk);
        #1;
        check("t6_valid", 32'(key_valid), 32'd1);
        check("t6_code", 32'(key_code), 32'd3);
        keys[0][3] = 1'b0;
        wait_held(1'b0, 20, "t6_release");
`endif

        // Two rows on column 0: lowest row wins
        keys[1][0] = 1'b1;
        keys[3][0] = 1'b1;
        push(1, 0);
        wait_held(1'b1, 200, "multi_held");
        check("multi_code", 32'(key_code), 32'd4);
        check("multi_row", 32'(key_row), 32'd1);
        keys[1][0] = 1'b0;
        keys[3][0] = 1'b0;
        wait_held(1'b0, 60, "multi_release");

        // Asynchronous reset while a press is pending
        wait_col(4'b0100, 40, "mid_align");
        keys[2][2] = 1'b1;
`ifdef KEYSCAN_DEBOUNCE_EN
        repeat (7) @(posedge clk);
`else
        repeat (2) @(posedge clk);
`endif
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_col", 32'(col_out), 32'd1);
        check("mid_rst_code", 32'(key_code), 32'd0);
        check("mid_rst_row", 32'(key_row), 32'd0);
        check("mid_rst_held", 32'(key_held), 32'd0);
        check("mid_rst_valid", 32'(key_valid), 32'd0);
        keys = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("end_pulses", 32'(n_pulses), 32'(n_expected));
        check("end_queue", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
